// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives the instruction memory request,
// and loads the IF/ID register with freeze hold-buffering and branch flush/discard.
module fetch_ctrl #(
    parameter int                  ADDR_W   = 32,
    parameter int                  INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC = 32'd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic [ADDR_W-1:0]  im_addr,
    output logic               im_req,
    input  logic [INSTR_W-1:0] im_instr,
    input  logic               im_ready,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [INSTR_W-1:0] id_instr,
    output logic               id_valid
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
    logic [ADDR_W-1:0]  id_pc_q, id_pc_d;
    logic [INSTR_W-1:0] id_instr_q, id_instr_d;
    logic               id_valid_q, id_valid_d;

    logic [ADDR_W-1:0]  pc_next_s;
    assign pc_next_s = pc_q + PC_STEP;

    // State register and all datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            hold_instr_q <= {INSTR_W{1'b0}};
            id_pc_q      <= {ADDR_W{1'b0}};
            id_instr_q   <= {INSTR_W{1'b0}};
            id_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            hold_instr_q <= hold_instr_d;
            id_pc_q      <= id_pc_d;
            id_instr_q   <= id_instr_d;
            id_valid_q   <= id_valid_d;
        end
    end

    // Next-state, PC update, IF/ID load and memory request outputs
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        hold_instr_d = hold_instr_q;
        id_pc_d      = id_pc_q;
        id_instr_d   = id_instr_q;
        id_valid_d   = id_valid_q;
        im_req       = 1'b1;
        im_addr      = pc_q;

        case (state_q)
            S_FETCH: begin
                im_req     = 1'b1;
                im_addr    = pc_q;
                req_addr_d = pc_q;
                if (branch_taken) begin
                    pc_d       = branch_addr;
                    id_pc_d    = {ADDR_W{1'b0}};
                    id_instr_d = {INSTR_W{1'b0}};
                    id_valid_d = 1'b0;
                    // An unanswered request must be drained before the target is fetched
                    state_d    = im_ready ? S_FETCH : S_DISCARD;
                end else if (im_ready && !freeze) begin
                    id_pc_d    = pc_next_s;
                    id_instr_d = im_instr;
                    id_valid_d = 1'b1;
                    pc_d       = pc_next_s;
                end else if (im_ready) begin
                    hold_instr_d = im_instr;
                    state_d      = S_HOLD;
                end else if (!freeze) begin
                    id_instr_d = {INSTR_W{1'b0}};
                    id_valid_d = 1'b0;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_HOLD: begin
                im_req  = 1'b0;
                im_addr = pc_q;
                if (branch_taken) begin
                    pc_d       = branch_addr;
                    id_pc_d    = {ADDR_W{1'b0}};
                    id_instr_d = {INSTR_W{1'b0}};
                    id_valid_d = 1'b0;
                    state_d    = S_FETCH;
                end else if (!freeze) begin
                    id_pc_d    = pc_next_s;
                    id_instr_d = hold_instr_q;
                    id_valid_d = 1'b1;
                    pc_d       = pc_next_s;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_DISCARD: begin
                im_req  = 1'b1;
                im_addr = req_addr_q;
                if (branch_taken) begin
                    pc_d    = branch_addr;
                    state_d = S_DISCARD;
                end else if (im_ready) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_DISCARD;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign id_pc    = id_pc_q;
    assign id_instr = id_instr_q;
    assign id_valid = id_valid_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by randomized
// branch/freeze/latency traffic, all checked against a behavioural fetch model.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] im_addr;
    logic        im_req;
    logic [31:0] im_instr;
    logic        im_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_valid;

    int vectors;
    int miscompares;

    // Behavioural model: PC, an optional buffered instruction taken during a freeze,
    // an optional abandoned request still awaiting its response, and the IF/ID contents.
    logic [31:0] m_pc;
    logic        m_have_buf;
    logic [31:0] m_buf;
    logic        m_draining;
    logic [31:0] m_drain_addr;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_instr;
    logic        m_id_valid;
    int          m_wait;
    int          m_lat;
    bit          m_rand_lat;

    fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .im_addr      (im_addr),
        .im_req       (im_req),
        .im_instr     (im_instr),
        .im_ready     (im_ready),
        .id_pc        (id_pc),
        .id_instr     (id_instr),
        .id_valid     (id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'hE3A00014;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_have_buf = 1'b0; m_buf = 32'd0;
        m_draining = 1'b0; m_drain_addr = 32'd0;
        m_id_pc = 32'd0; m_id_instr = 32'd0; m_id_valid = 1'b0;
        m_wait = 0;
    endtask

    task automatic flush_model();
        m_id_pc = 32'd0; m_id_instr = 32'd0; m_id_valid = 1'b0;
    endtask

    task automatic deliver(input logic [31:0] ins);
        m_id_pc    = m_pc + 32'd4;
        m_id_instr = ins;
        m_id_valid = 1'b1;
        m_pc       = m_pc + 32'd4;
    endtask

    task automatic model_step(input logic br, input logic [31:0] ba, input logic fz,
                              input logic rdy, input logic [31:0] ins);
        if (m_have_buf) begin
            if (br) begin
                m_pc = ba; flush_model(); m_have_buf = 1'b0;
            end else if (!fz) begin
                deliver(m_buf); m_have_buf = 1'b0;
            end
        end else if (m_draining) begin
            if (br) m_pc = ba;
            else if (rdy) m_draining = 1'b0;
        end else begin
            if (br) begin
                m_drain_addr = m_pc;
                m_draining   = !rdy;
                m_pc = ba; flush_model();
            end else if (rdy && !fz) begin
                deliver(ins);
            end else if (rdy) begin
                m_buf = ins; m_have_buf = 1'b1;
            end else if (!fz) begin
                m_id_valid = 1'b0; m_id_instr = 32'd0;
            end
        end
    endtask

    // One clock: drive inputs, check request outputs mid-cycle, check IF/ID after the edge
    task automatic step(input logic br, input logic [31:0] ba, input logic fz);
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        rdy;
        exp_req  = !m_have_buf;
        exp_addr = m_draining ? m_drain_addr : m_pc;
        rdy      = exp_req && (m_wait >= m_lat);
        branch_taken = br;
        branch_addr  = ba;
        freeze       = fz;
        im_ready     = rdy;
        im_instr     = mem_word(exp_addr);
        @(negedge clk);
        check("im_req", {31'd0, im_req}, {31'd0, exp_req});
        if (exp_req) check("im_addr", im_addr, exp_addr);
        @(posedge clk);
        #1;
        model_step(br, ba, fz, rdy, mem_word(exp_addr));
        if (exp_req && rdy) begin
            m_wait = 0;
            if (m_rand_lat) m_lat = $urandom_range(0, 3);
        end else if (exp_req) begin
            m_wait++;
        end
        check("id_valid", {31'd0, id_valid}, {31'd0, m_id_valid});
        check("id_instr", id_instr, m_id_instr);
        check("id_pc", id_pc, m_id_pc);
        if (m_id_valid) check("id_instr_vs_mem", id_instr, mem_word(m_id_pc - 32'd4));
    endtask

    task automatic check_reset_outputs();
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_instr", id_instr, 32'd0);
        check("rst_id_valid", {31'd0, id_valid}, 32'd0);
        check("rst_im_req", {31'd0, im_req}, 32'd1);
        check("rst_im_addr", im_addr, 32'd0);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        m_lat = 0; m_rand_lat = 1'b0;
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0;
        im_ready = 1'b0; im_instr = 32'd0;
        model_reset();
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Stream to pc=12, freeze 3 cycles, release, continue to id_pc=24
        repeat (3) step(1'b0, 32'd0, 1'b0);
        check("pc12_before_freeze", id_pc, 32'd12);
        repeat (3) step(1'b0, 32'd0, 1'b1);
        check("freeze_id_pc_held", id_pc, 32'd12);
        check("freeze_im_req_low", {31'd0, im_req}, 32'd0);
        step(1'b0, 32'd0, 1'b0);
        check("release_id_pc", id_pc, 32'd16);
        check("release_id_instr", id_instr, mem_word(32'd12));
        repeat (2) step(1'b0, 32'd0, 1'b0);
        check("stream_end_id_pc", id_pc, 32'd24);

        // Branch together with freeze: flush, then target
        step(1'b1, 32'h40, 1'b1);
        check("branch_flush_valid", {31'd0, id_valid}, 32'd0);
        check("branch_flush_instr", id_instr, 32'd0);
        step(1'b0, 32'd0, 1'b0);
        check("branch_target_pc", id_pc, 32'h44);
        check("branch_target_instr", id_instr, mem_word(32'h40));

        // Slow memory, 3 wait cycles per request
        m_lat = 3;
        repeat (12) step(1'b0, 32'd0, 1'b0);
        check("slow_id_pc", id_pc, 32'h50);

        // Discard: branch to 0x100 while a slow fetch of 0x20 is pending
        m_lat = 0;
        step(1'b1, 32'h20, 1'b0);
        m_lat = 3;
        step(1'b1, 32'h100, 1'b0);
        repeat (7) step(1'b0, 32'd0, 1'b0);
        check("discard_target_pc", id_pc, 32'h104);
        check("discard_target_instr", id_instr, mem_word(32'h100));

        // Wrap at the top of the address space, then async reset inside HOLD
        m_lat = 0;
        step(1'b1, 32'hFFFF_FFFC, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        check("wrap_id_pc", id_pc, 32'd0);
        step(1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 32'd0, 1'b0);
        check("post_reset_instr", id_instr, 32'hE3A00014);

        // Randomized traffic
        m_rand_lat = 1'b1;
        m_lat = $urandom_range(0, 3);
        for (int i = 0; i < 400; i++) begin
            logic        br;
            logic        fz;
            logic [31:0] ba;
            br = ($urandom_range(0, 9) == 0);
            fz = ($urandom_range(0, 9) < 3);
            ba = $urandom() & 32'h0000_FFFC;
            step(br, ba, fz);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller for the 5-stage ARM-subset pipeline. Owns the program counter, issues requests to the instruction memory (combinational, or a multi-cycle source with a ready handshake), and loads the IF/ID pipeline register. Handles hazard-unit freeze with a one-entry hold buffer, and handles EXE-stage branch redirects with flush and stale-response discard.

## Interface
- ADDR_W, 32, PC / instruction-address width
- INSTR_W, 32, instruction width
- RESET_PC, 32'd0, PC value after reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- freeze  in  1  hazard-unit stall; IF/ID and PC must not advance
- branch_taken  in  1  redirect from EXE; priority over freeze
- branch_addr  in  ADDR_W  redirect target
- im_addr  out  ADDR_W  instruction-memory address (PC_in of the memory)
- im_req  out  1  fetch request active
- im_instr  in  INSTR_W  returned instruction
- im_ready  in  1  im_instr valid this cycle; tie 1 for combinational memory
- id_pc  out  ADDR_W  PC+4 of the instruction in IF/ID
- id_instr  out  INSTR_W  instruction in IF/ID; 0 when not valid
- id_valid  out  1  IF/ID holds a real instruction

## Operation
- Registers: pc, req_addr, hold_instr, state (FETCH, HOLD, DISCARD), and the IF/ID registers.
- Reset (async, any state):
  - pc=RESET_PC, state=FETCH.
  - id_pc=0, id_instr=0, id_valid=0, hold_instr=0.
  - im_req=1 and im_addr=RESET_PC immediately after reset release.
- FETCH:
  - Outputs: im_req=1, im_addr=pc, req_addr<=pc.
  - branch_taken: pc<=branch_addr and IF/ID flushed (valid=0, instr=0, id_pc=0). Next state is FETCH if im_ready, else DISCARD.
  - else im_ready & !freeze: IF/ID<={pc+4, im_instr, 1} and pc<=pc+4.
  - else im_ready & freeze: hold_instr<=im_instr, go to HOLD. IF/ID and pc unchanged.
  - else !im_ready: IF/ID holds if freeze; otherwise id_valid<=0 and id_instr<=0 (bubble). pc unchanged.
- HOLD:
  - Outputs: im_req=0.
  - branch_taken: pc<=branch_addr, flush, go to FETCH.
  - !freeze: IF/ID<={pc+4, hold_instr, 1}, pc<=pc+4, go to FETCH.
  - freeze: stay.
- DISCARD:
  - Outputs: im_req=1, im_addr=req_addr (held stable for the abandoned request). IF/ID stays flushed.
  - branch_taken: pc<=branch_addr (latest wins), stay.
  - im_ready: response dropped, go to FETCH.
- Arithmetic: pc+4 is modulo 2^ADDR_W, so 0xFFFFFFFC wraps to 0. branch_addr is used as given; no alignment check.
- Simultaneous events: branch_taken beats freeze and im_ready in every state. A response that arrives in the same cycle as a branch is never written to IF/ID.
- Invariant: at most one outstanding request. im_addr never changes while im_req=1 and im_ready=0.

## Timing
- Registered outputs: id_pc, id_instr, id_valid. im_req and im_addr are combinational from state, pc and req_addr.
- With im_ready tied 1 and no freeze:
  - One instruction per cycle.
  - The instruction at RESET_PC is in IF/ID after the first rising edge following reset release.
- Branch penalty with im_ready=1: branch_taken sampled at edge n gives a bubble in IF/ID after n. The target instruction is in IF/ID after edge n+1.
- Multi-cycle memory: an instruction reaches IF/ID on the edge where im_ready=1, at the earliest. A freeze during the wait costs no refetch.
- Freeze release from HOLD: the held instruction is in IF/ID on the first edge with freeze=0.

## Test plan
- **Reset and stream:** reset, then im_ready=1 with memory returning the contents of address 0..20 (e.g. 0xE3A00014 at 0). Required: id_instr follows the sequence one per cycle, id_pc=4,8,...,24, id_valid=1 throughout.
- **Freeze:** freeze=1 for 3 cycles while pc=12. Required:
  - IF/ID holds the instruction from address 8 and pc holds 12.
  - State goes to HOLD with im_req=0.
  - On release, IF/ID gets the instruction from 12 with id_pc=16.
  - No address is skipped or duplicated.
- **Branch:** branch_taken=1 with branch_addr=0x40 and freeze=1 in the same cycle. Required:
  - Flush next edge: id_valid=0, id_instr=0.
  - Then IF/ID holds the instruction from 0x40 with id_pc=0x44.
- **Slow memory:** im_ready asserted 3 cycles after each request. Required:
  - im_addr stable during each wait.
  - id_valid=0 bubbles while waiting.
  - Each instruction is delivered exactly once.
- **Discard:** branch to 0x100 while a slow request to 0x20 is outstanding. Required:
  - im_addr stays 0x20 until im_ready.
  - The 0x20 response never appears in IF/ID.
  - The next request goes to 0x100.
- **Wrap and async reset:** force pc=0xFFFFFFFC via branch; the next pc is 0. Assert rst mid-HOLD; all outputs clear immediately, without waiting for a clock edge.
